// File: rtl/pll_lock_mgr.sv
// pll_lock_mgr: reset sequencer and lock qualifier for a PLL.
// It drives the PLL reset and re-times the asynchronous lock into clk.
// It releases the system reset only after lock has been stable for a full window.
// Lock loss restarts the sequence. A lock timeout triggers a retry.
// After RETRY_MAX consecutive timeouts it latches a sticky fail.
// FSM state is held in state_q, a named internal signal that a checker can probe.
module pll_lock_mgr #(
  parameter int PWR_RST_CYC  = 8,
  parameter int LOCK_TIMEOUT = 200000,
  parameter int LOCK_STABLE  = 1024,
  parameter int RETRY_MAX    = 3,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic       fail
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  // Terminal counts: each phase ends when the shared counter reaches N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PWR_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_LIM   = 4'(RETRY_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             sync1_q, sync1_d;
  logic             lock_s_q, lock_s_d;
  logic             pll_rst_q, pll_rst_d;
  logic             locked_q, locked_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             lock_lost_q, lock_lost_d;
  logic             fail_q, fail_d;

  // Two-flop synchronizer for the asynchronous lock; the FSM only ever looks at lock_s_q.
  always_comb begin
    sync1_d  = pll_lock;
    lock_s_d = sync1_q;
  end

  // State register and phase counter; rst forces the power-up reset attempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RST;
      cnt_q    <= '0;
      retry_q  <= '0;
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      sync1_q  <= sync1_d;
      lock_s_q <= lock_s_d;
    end
  end

  // Next-state, counter and retry bookkeeping; restart overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = ST_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = (retry_q == RETRY_LIM) ? retry_q : retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIM) ? ST_FAIL : ST_RST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_RST;
            cnt_d   = '0;
          end
        end
        ST_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state, so every output is a plain flop.
  always_comb begin
    pll_rst_d   = (state_d == ST_RST) || (state_d == ST_FAIL);
    locked_d    = (state_d == ST_RUN);
    sys_rst_n_d = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    // The lock-loss pulse depends only on the RUN exit condition, so it still fires alongside restart.
    lock_lost_d = (state_q == ST_RUN) && !lock_s_q;
  end

  // Output registers hold their reset values while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pll_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      locked_q    <= locked_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_lost_q <= lock_lost_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Testbench for pll_lock_mgr with a small configuration (8 / 64 / 4 / 3).
// Each expected output change is queued with the clock edge that should produce it.
// A monitor watches the output vector. Whenever the vector changes, it pops one entry and compares both the edge number and the values.
// A change with nothing queued is reported as a failure. So is an entry that never arrives.
module tb_pll_lock_mgr;

  localparam int W = 41;  // {edge[31:0], pll_rst, sys_rst_n, locked, lock_lost, retry_cnt[3:0], fail}

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic       fail;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           cyc;
  int           n_tests;
  int           n_fail;
  logic [8:0]   prev_vec;

  pll_lock_mgr #(
    .PWR_RST_CYC (8),
    .LOCK_TIMEOUT(64),
    .LOCK_STABLE (4),
    .RETRY_MAX   (3),
    .CNT_W       (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_rst  (pll_rst),
    .sys_rst_n(sys_rst_n),
    .locked   (locked),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt),
    .fail     (fail)
  );

  // Clock and edge counter: cyc equals the index of the most recent rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog: the whole run is only a few thousand cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Queue one expected output change at a given rising edge.
  task automatic expect_at(input int edge_n, input logic pr, input logic srn, input logic lk,
                           input logic ll, input logic [3:0] rc, input logic fl, input string name);
    exp_q.push_back({32'(edge_n), pr, srn, lk, ll, rc, fl});
    name_q.push_back(name);
  endtask

  // Advance n rising edges, then move 1 time unit past the edge before driving inputs.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare on every change of the output vector, sampled on the falling edge.
  initial prev_vec = 'x;
  always @(negedge clk) begin
    logic [8:0]   vec;
    logic [W-1:0] e;
    string        nm;
    vec = {pll_rst, sys_rst_n, locked, lock_lost, retry_cnt, fail};
    if (vec !== prev_vec) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: edge %0d got %b, nothing expected", cyc, vec);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e[W-1:9] !== 32'(cyc) || e[8:0] !== vec) begin
          n_fail++;
          $display("FAIL %s: got edge %0d vec %b, expected edge %0d vec %b",
                   nm, cyc, vec, e[W-1:9], e[8:0]);
        end
      end
      prev_vec = vec;
    end
  end

  // Stimulus: directed scenarios, each queuing its hand-computed output changes.
  initial begin
    int t;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    pll_lock = 1'b0;
    restart  = 1'b0;

    // The first edge under rst brings outputs to their reset values.
    expect_at(1, 1, 0, 0, 0, 4'd0, 0, "reset_values");
    step(3);

    // Power-up: pll_rst is high for 8 cycles, then lock arrives at cycle 10.
    // Locked is seen 7 edges later (2 sync + 1 WAIT + 4 STABLE).
    rst = 1'b0;
    t = cyc;
    expect_at(t + 8, 0, 0, 0, 0, 4'd0, 0, "t1_pll_rst_fall");
    step(10);
    pll_lock = 1'b1;
    t = cyc;
    expect_at(t + 7, 0, 1, 1, 0, 4'd0, 0, "t1_locked");
    step(12);

    // Lock loss in RUN: one-cycle lock_lost 3 edges after the drop, then an 8-cycle pll_rst.
    pll_lock = 1'b0;
    t = cyc;
    expect_at(t + 3, 1, 0, 0, 1, 4'd0, 0, "t3_lock_lost");
    expect_at(t + 4, 1, 0, 0, 0, 4'd0, 0, "t3_pulse_end");
    expect_at(t + 11, 0, 0, 0, 0, 4'd0, 0, "t3_pll_rst_fall");
    step(20);

    // Glitch in WAIT: 2 cycles high, 3 low, then steady high. There is no output change until final rise + 7.
    pll_lock = 1'b1;
    t = cyc;
    step(2);
    pll_lock = 1'b0;
    step(3);
    pll_lock = 1'b1;
    expect_at(t + 12, 0, 1, 1, 0, 4'd0, 0, "t2_relock_after_glitch");
    step(12);

    // Lock tied low: three timeouts, each 8 + 64 cycles, end in FAIL with retry_cnt=3.
    pll_lock = 1'b0;
    t = cyc;
    expect_at(t + 3, 1, 0, 0, 1, 4'd0, 0, "t4_lock_lost");
    expect_at(t + 4, 1, 0, 0, 0, 4'd0, 0, "t4_pulse_end");
    expect_at(t + 11, 0, 0, 0, 0, 4'd0, 0, "t4_rst_fall_a0");
    expect_at(t + 75, 1, 0, 0, 0, 4'd1, 0, "t4_timeout1");
    expect_at(t + 83, 0, 0, 0, 0, 4'd1, 0, "t4_rst_fall_a1");
    expect_at(t + 147, 1, 0, 0, 0, 4'd2, 0, "t4_timeout2");
    expect_at(t + 155, 0, 0, 0, 0, 4'd2, 0, "t4_rst_fall_a2");
    expect_at(t + 219, 1, 0, 0, 0, 4'd3, 1, "t4_fail");
    step(219 + 500);

    // Restart from FAIL with lock present: flags clear, 8-cycle pll_rst, then lock qualifies.
    pll_lock = 1'b1;
    restart  = 1'b1;
    t = cyc;
    expect_at(t + 1, 1, 0, 0, 0, 4'd0, 0, "t5_restart_clear");
    expect_at(t + 9, 0, 0, 0, 0, 4'd0, 0, "t5_pll_rst_fall");
    expect_at(t + 14, 0, 1, 1, 0, 4'd0, 0, "t5_locked");
    step(1);
    restart = 1'b0;
    step(20);

    // rst asserted mid-STABLE (counter at 1), then a clean sequence.
    pll_lock = 1'b0;
    t = cyc;
    expect_at(t + 3, 1, 0, 0, 1, 4'd0, 0, "t6a_lock_lost");
    expect_at(t + 4, 1, 0, 0, 0, 4'd0, 0, "t6a_pulse_end");
    expect_at(t + 11, 0, 0, 0, 0, 4'd0, 0, "t6a_pll_rst_fall");
    step(5);
    pll_lock = 1'b1;
    step(8);
    rst = 1'b1;
    expect_at(t + 14, 1, 0, 0, 0, 4'd0, 0, "t6a_rst_in_stable");
    step(1);
    rst = 1'b0;
    t = cyc;
    expect_at(t + 8, 0, 0, 0, 0, 4'd0, 0, "t6a_pll_rst_fall2");
    expect_at(t + 13, 0, 1, 1, 0, 4'd0, 0, "t6a_locked");
    step(20);

    // rst asserted mid-RUN.
    rst = 1'b1;
    t = cyc;
    expect_at(t + 1, 1, 0, 0, 0, 4'd0, 0, "t6b_rst_in_run");
    step(1);
    rst = 1'b0;
    t = cyc;
    expect_at(t + 8, 0, 0, 0, 0, 4'd0, 0, "t6b_pll_rst_fall");
    expect_at(t + 13, 0, 1, 1, 0, 4'd0, 0, "t6b_locked");
    step(20);

    // restart on the same edge as a RUN lock loss: lock_lost still pulses.
    pll_lock = 1'b0;
    t = cyc;
    expect_at(t + 3, 1, 0, 0, 1, 4'd0, 0, "restart_lock_lost");
    expect_at(t + 4, 1, 0, 0, 0, 4'd0, 0, "restart_pulse_end");
    expect_at(t + 11, 0, 0, 0, 0, 4'd0, 0, "restart_pll_rst_fall");
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(20);

    // Any expectation still queued never happened.
    while (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: change never seen, expected edge %0d vec %b", nm, e[W-1:9], e[8:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
